// File: rtl/medidor_pwm_pkg.sv
// medidor_pwm_pkg: shared definitions for the PWM/servo pulse meter.
//   - estado_t: FSM state encoding, also exported on the estado_db debug port.
//   - N_PADRAO / TIMEOUT_PADRAO: defaults for 50 MHz clock and 50 Hz servo framing.
package medidor_pwm_pkg;

    typedef enum logic [2:0] {
        Inicial      = 3'd0,
        EsperaSubida = 3'd1,
        MedeAlto     = 3'd2,
        MedeBaixo    = 3'd3
    } estado_t;

    // 20 bits hold one full 20 ms servo frame at 50 MHz (1_000_000 ticks).
    localparam int unsigned N_PADRAO       = 20;
    localparam int unsigned TIMEOUT_PADRAO = 1_000_000;

endpackage

// File: rtl/detector_borda.sv
// detector_borda: two-FF synchronizer plus edge register for an asynchronous input.
//   clock      in   system clock, rising edge
//   zera_as_n  in   asynchronous reset, active-low
//   entrada    in   asynchronous input
//   s          out  synchronized level
//   sobe       out  one-cycle rising-edge pulse of s
//   desce      out  one-cycle falling-edge pulse of s
//   valido     out  s holds a real input sample (pipeline filled since reset)
module detector_borda (
    input  logic clock,
    input  logic zera_as_n,
    input  logic entrada,
    output logic s,
    output logic sobe,
    output logic desce,
    output logic valido
);

    logic sinc1_q, sinc2_q, ant_q;
    logic cheio1_q, cheio2_q;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            sinc1_q  <= 1'b0;
            sinc2_q  <= 1'b0;
            ant_q    <= 1'b0;
            cheio1_q <= 1'b0;
            cheio2_q <= 1'b0;
        end else begin
            sinc1_q  <= entrada;
            sinc2_q  <= sinc1_q;
            ant_q    <= sinc2_q;
            cheio1_q <= 1'b1;
            cheio2_q <= cheio1_q;
        end
    end

    assign s      = sinc2_q;
    assign sobe   = sinc2_q & ~ant_q;
    assign desce  = ~sinc2_q & ant_q;
    // The cleared synchronizer reads as 0 right after reset; without this a
    // pulse already high at release would look like a fresh rising edge.
    assign valido = cheio2_q;

endmodule

// File: rtl/medidor_pwm.sv
// medidor_pwm: measures high width and period of a PWM/servo input in clock ticks.
//   clock         in   system clock, rising edge
//   zera_as_n     in   asynchronous reset, active-low
//   habilita      in   measurement enable; 0 returns the FSM to Inicial
//   pwm_in        in   asynchronous PWM input
//   largura       out  last valid high width (ticks)
//   periodo       out  last valid rising-to-rising period (ticks)
//   pronto        out  one-cycle strobe, largura/periodo updated this cycle
//   erro_timeout  out  sticky timeout flag, cleared by the next pronto
//   estado_db     out  current FSM state code
module medidor_pwm
    import medidor_pwm_pkg::*;
#(
    parameter int unsigned N        = N_PADRAO,
    parameter int unsigned TIMEOUT  = TIMEOUT_PADRAO,
    parameter int unsigned LARG_MIN = 1
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic         habilita,
    input  logic         pwm_in,
    output logic [N-1:0] largura,
    output logic [N-1:0] periodo,
    output logic         pronto,
    output logic         erro_timeout,
    output logic [2:0]   estado_db
);

    localparam logic [N-1:0] LIMITE = N'(TIMEOUT);
    localparam logic [N-1:0] MINIMO = N'(LARG_MIN);
    localparam logic [N-1:0] UM     = N'(1);

    logic s, sobe, desce, valido;

    detector_borda u_detector_borda (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .entrada   (pwm_in),
        .s         (s),
        .sobe      (sobe),
        .desce     (desce),
        .valido    (valido)
    );

    estado_t      estado_q, estado_d;
    logic [N-1:0] cont_alto_q, cont_alto_d;
    logic [N-1:0] cont_per_q, cont_per_d;
    logic [N-1:0] alto_q, alto_d;
    logic [N-1:0] largura_q, largura_d;
    logic [N-1:0] periodo_q, periodo_d;
    logic         pronto_q, pronto_d;
    logic         erro_q, erro_d;

    always_comb begin
        estado_d    = estado_q;
        cont_alto_d = cont_alto_q;
        cont_per_d  = cont_per_q;
        alto_d      = alto_q;
        largura_d   = largura_q;
        periodo_d   = periodo_q;
        pronto_d    = 1'b0;
        erro_d      = erro_q;

        if (!habilita) begin
            estado_d    = Inicial;
            cont_alto_d = '0;
            cont_per_d  = '0;
        end else begin
            unique case (estado_q)
                Inicial: begin
                    cont_alto_d = '0;
                    cont_per_d  = '0;
                    // Wait for low so a pulse already in progress is discarded.
                    if (valido && !s) begin
                        estado_d   = EsperaSubida;
                        cont_per_d = UM;
                    end
                end

                // cont_per doubles as the wait counter here.
                EsperaSubida: begin
                    if (sobe) begin
                        estado_d    = MedeAlto;
                        cont_alto_d = UM;
                        cont_per_d  = UM;
                    end else if (cont_per_q == LIMITE) begin
                        estado_d   = Inicial;
                        erro_d     = 1'b1;
                        cont_per_d = '0;
                    end else begin
                        cont_per_d = cont_per_q + UM;
                    end
                end

                MedeAlto: begin
                    if (desce) begin
                        estado_d   = MedeBaixo;
                        alto_d     = cont_alto_q;
                        cont_per_d = cont_per_q + UM;
                    end else if (cont_per_q == LIMITE) begin
                        estado_d    = Inicial;
                        erro_d      = 1'b1;
                        cont_alto_d = '0;
                        cont_per_d  = '0;
                    end else begin
                        cont_alto_d = cont_alto_q + UM;
                        cont_per_d  = cont_per_q + UM;
                    end
                end

                // sobe is checked before the limit so a period of exactly
                // TIMEOUT ticks is still published.
                MedeBaixo: begin
                    if (sobe) begin
                        if (alto_q >= MINIMO) begin
                            largura_d = alto_q;
                            periodo_d = cont_per_q;
                            pronto_d  = 1'b1;
                            erro_d    = 1'b0;
                        end
                        // Restart immediately: no dead cycle between periods.
                        estado_d    = MedeAlto;
                        cont_alto_d = UM;
                        cont_per_d  = UM;
                    end else if (cont_per_q == LIMITE) begin
                        estado_d    = Inicial;
                        erro_d      = 1'b1;
                        cont_alto_d = '0;
                        cont_per_d  = '0;
                    end else begin
                        cont_per_d = cont_per_q + UM;
                    end
                end

                default: begin
                    estado_d    = Inicial;
                    cont_alto_d = '0;
                    cont_per_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_q    <= Inicial;
            cont_alto_q <= '0;
            cont_per_q  <= '0;
            alto_q      <= '0;
            largura_q   <= '0;
            periodo_q   <= '0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cont_alto_q <= cont_alto_d;
            cont_per_q  <= cont_per_d;
            alto_q      <= alto_d;
            largura_q   <= largura_d;
            periodo_q   <= periodo_d;
            pronto_q    <= pronto_d;
            erro_q      <= erro_d;
        end
    end

    assign largura      = largura_q;
    assign periodo      = periodo_q;
    assign pronto       = pronto_q;
    assign erro_timeout = erro_q;
    assign estado_db    = estado_q;

endmodule

// File: tb/tb_medidor_pwm.sv
// tb_medidor_pwm: directed PWM waveforms; expected measurements go into a queue
// and a monitor compares them whenever the DUT strobes pronto.
module tb_medidor_pwm;

    localparam int unsigned N    = 20;
    localparam int unsigned TMO  = 5000;
    localparam int unsigned LMIN = 3;

    logic         clock = 1'b0;
    logic         zera_as_n;
    logic         habilita;
    logic         pwm_in;
    logic [N-1:0] largura;
    logic [N-1:0] periodo;
    logic         pronto;
    logic         erro_timeout;
    logic [2:0]   estado_db;

    int vetores = 0;
    int erros   = 0;

    typedef struct {
        logic [N-1:0] w;
        logic [N-1:0] p;
    } esperado_t;

    esperado_t fila[$];

    always #5 clock = ~clock;

    medidor_pwm #(
        .N        (N),
        .TIMEOUT  (TMO),
        .LARG_MIN (LMIN)
    ) dut (
        .clock        (clock),
        .zera_as_n    (zera_as_n),
        .habilita     (habilita),
        .pwm_in       (pwm_in),
        .largura      (largura),
        .periodo      (periodo),
        .pronto       (pronto),
        .erro_timeout (erro_timeout),
        .estado_db    (estado_db)
    );

    task automatic verifica(input string nome, input logic [31:0] obtido,
                            input logic [31:0] esperado);
        vetores++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    task automatic espera_pronto(input int w, input int p);
        esperado_t e;
        e.w = N'(w);
        e.p = N'(p);
        fila.push_back(e);
    endtask

    // Hold pwm_in at v for exactly n sampling edges; returns just after the last.
    task automatic nivel(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulso(input int h, input int l, input bit publica, input int w, input int p);
        if (publica) espera_pronto(w, p);
        nivel(1'b1, h);
        nivel(1'b0, l);
    endtask

    // Monitor: pops one expectation per pronto strobe.
    logic pronto_ant = 1'b0;
    always @(negedge clock) begin
        esperado_t e;
        if (pronto_ant) verifica("pronto_um_ciclo", {31'd0, pronto}, 32'd0);
        if (zera_as_n === 1'b1 && pronto === 1'b1) begin
            if (fila.size() == 0) begin
                vetores++;
                erros++;
                $display("FAIL pronto_espurio: got pronto=1, expected none (largura=%0d periodo=%0d t=%0t)",
                         largura, periodo, $time);
            end else begin
                e = fila.pop_front();
                verifica("largura", largura, e.w);
                verifica("periodo", periodo, e.p);
                verifica("erro_no_pronto", {31'd0, erro_timeout}, 32'd0);
            end
        end
        pronto_ant <= (zera_as_n === 1'b1) && (pronto === 1'b1);
    end

    initial begin
        int c;
        zera_as_n = 1'b0;
        habilita  = 1'b1;
        pwm_in    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        verifica("reset_largura", largura, 0);
        verifica("reset_periodo", periodo, 0);
        verifica("reset_pronto", {31'd0, pronto}, 0);
        verifica("reset_erro", {31'd0, erro_timeout}, 0);
        verifica("reset_estado", {29'd0, estado_db}, 0);
        zera_as_n = 1'b1;

        // Input low from the start: timeout exactly TMO cycles into EsperaSubida.
        c = 0;
        while (estado_db !== 3'd1 && c < 10) begin
            @(negedge clock);
            c++;
        end
        verifica("estado_espera", {29'd0, estado_db}, 1);
        c = 0;
        while (erro_timeout !== 1'b1 && c < 6000) begin
            @(negedge clock);
            c++;
        end
        verifica("ciclos_timeout_espera", c, TMO);
        verifica("largura_apos_timeout", largura, 0);
        verifica("periodo_apos_timeout", periodo, 0);
        @(posedge clock);
        #1;

        // Steady 150/1000; the first rise only starts a measurement.
        pulso(150, 850, 0, 0, 0);
        repeat (3) pulso(150, 850, 1, 150, 1000);
        verifica("erro_limpo_por_pronto", {31'd0, erro_timeout}, 0);

        // One-cycle habilita drop in the low phase: outputs held, restart.
        espera_pronto(150, 1000);
        nivel(1'b1, 150);
        nivel(1'b0, 400);
        habilita = 1'b0;
        nivel(1'b0, 1);
        habilita = 1'b1;
        verifica("habilita_estado", {29'd0, estado_db}, 0);
        verifica("habilita_largura", largura, 150);
        verifica("habilita_periodo", periodo, 1000);
        nivel(1'b0, 449);
        pulso(150, 850, 0, 0, 0);
        pulso(150, 850, 1, 150, 1000);

        // Reset in the low phase.
        espera_pronto(150, 1000);
        nivel(1'b1, 150);
        nivel(1'b0, 300);
        zera_as_n = 1'b0;
        #1;
        verifica("zera_baixo_largura", largura, 0);
        verifica("zera_baixo_periodo", periodo, 0);
        verifica("zera_baixo_estado", {29'd0, estado_db}, 0);
        nivel(1'b0, 5);
        zera_as_n = 1'b1;
        nivel(1'b0, 545);
        pulso(150, 850, 0, 0, 0);
        pulso(150, 850, 1, 150, 1000);

        // Reset released while the input is high: that partial pulse is ignored.
        espera_pronto(150, 1000);
        nivel(1'b1, 50);
        zera_as_n = 1'b0;
        nivel(1'b1, 5);
        zera_as_n = 1'b1;
        nivel(1'b1, 95);
        verifica("meio_pulso_estado", {29'd0, estado_db}, 0);
        nivel(1'b0, 850);
        pulso(150, 850, 0, 0, 0);
        pulso(150, 850, 1, 150, 1000);

        // Period of exactly TMO: the rise beats the timeout.
        pulso(150, 4850, 1, 150, 1000);
        pulso(150, 850, 1, 150, 5000);
        verifica("erro_periodo_limite", {31'd0, erro_timeout}, 0);

        // One-tick glitch: cuts the current period, then its own period is dropped.
        espera_pronto(150, 1000);
        nivel(1'b1, 150);
        nivel(1'b0, 400);
        espera_pronto(150, 550);
        nivel(1'b1, 1);
        nivel(1'b0, 449);
        pulso(150, 850, 0, 0, 0);
        pulso(150, 850, 1, 150, 1000);

        // Stuck high: that rise publishes the previous period, then times out.
        espera_pronto(150, 1000);
        pwm_in = 1'b1;
        c = 0;
        while (erro_timeout !== 1'b1 && c < 6000) begin
            @(negedge clock);
            c++;
        end
        verifica("ciclos_timeout_alto", c, TMO + 4);
        verifica("alto_largura_mantida", largura, 150);
        verifica("alto_periodo_mantido", periodo, 1000);
        verifica("alto_estado", {29'd0, estado_db}, 0);
        @(posedge clock);
        #1;
        nivel(1'b1, 100);
        verifica("alto_erro_pegajoso", {31'd0, erro_timeout}, 1);
        nivel(1'b0, 850);
        pulso(150, 850, 0, 0, 0);
        pulso(150, 850, 1, 150, 1000);
        verifica("erro_limpo_final", {31'd0, erro_timeout}, 0);

        nivel(1'b0, 20);
        verifica("fila_vazia", fila.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/medidor_pwm.md
Name: medidor_pwm

Overview:
- Receiver end of the drone PWM path: measures high time and period of an incoming PWM/servo signal, in clock ticks.
- The transmit side builds the same waveform from a modulo-M counter and its end-of-count flag.
- Output feeds the control FSM, which reads each new measurement through a one-cycle `pronto` strobe.
- Detects a stuck or missing input through a timeout.

Parameters:
- N, 20, width of the measurement registers and internal counters.
- TIMEOUT, 1000000, tick limit for any single phase; must satisfy 2 <= TIMEOUT <= 2^N - 1.
- LARG_MIN, 1, minimum valid high width in ticks; shorter pulses are glitches.

Ports:
- clock  in  1  system clock, rising edge.
- zera_as_n  in  1  asynchronous reset, active-low.
- habilita  in  1  enables measurement; 0 forces the FSM to INICIAL synchronously.
- pwm_in  in  1  asynchronous PWM input.
- largura  out  N  last valid high width in ticks.
- periodo  out  N  last valid period (rising edge to rising edge) in ticks.
- pronto  out  1  one-cycle strobe; largura and periodo updated this cycle.
- erro_timeout  out  1  sticky flag; set on timeout, cleared on the next pronto or on reset.
- estado_db  out  3  current FSM state code, for debug display.

Behaviour:
- Reset (zera_as_n=0, asynchronous):
  - FSM goes to INICIAL; synchronizer FFs are cleared.
  - largura=0, periodo=0, pronto=0, erro_timeout=0, both counters=0.
- Input path:
  - Two-FF synchronizer produces s.
  - One more FF holds s_ant.
  - sobe = s & ~s_ant; desce = ~s & s_ant.
  - Input-to-edge latency is 3 clocks, constant, so it does not bias the widths.
- Counters cont_alto and cont_per, N bits:
  - clear synchronously;
  - increment by 1 per enabled cycle;
  - never wrap, because timeout triggers first.
- FSM states:
  - INICIAL: wait for s=0, then go to ESPERA_SUBIDA. This discards a pulse already in progress at start.
  - ESPERA_SUBIDA: on sobe, set cont_alto=1 and cont_per=1, go to MEDE_ALTO. If no sobe after TIMEOUT cycles here, timeout.
  - MEDE_ALTO: cont_alto and cont_per increment each cycle while s=1.
    - On desce: latch the high width internally as cont_alto, go to MEDE_BAIXO.
    - If cont_per reaches TIMEOUT: timeout (stuck high).
  - MEDE_BAIXO: cont_per increments each cycle.
    - On sobe, if width >= LARG_MIN: register largura=width and periodo=cont_per, pulse pronto, clear erro_timeout, restart with cont_alto=1 and cont_per=1, go to MEDE_ALTO. No dead cycle, so back-to-back periods are all measured.
    - On sobe with width < LARG_MIN: discard silently and restart measurement the same way.
    - If cont_per reaches TIMEOUT: timeout.
- Timeout action:
  - erro_timeout=1; go to INICIAL.
  - largura and periodo keep their previous values.
  - No pronto is generated.
- pronto timing: pronto is high for exactly one clock, the cycle after sobe is detected. largura and periodo change only in that same edge.
- habilita=0 has priority over all transitions:
  - FSM goes to INICIAL next clock;
  - counters are cleared;
  - outputs hold their values;
  - erro_timeout is unchanged.
- Reset mid-measurement aborts it with no pronto. After release, the first valid result requires one full low-to-high-to-low-to-high cycle.
- Simultaneous sobe and timeout in MEDE_BAIXO: sobe wins, so the measurement is published.
- Duty 0% or 100%: these produce only timeouts, never pronto.

Decomposition:
- Shared package:
  - FSM state encodings, 3-bit: INICIAL=0, ESPERA_SUBIDA=1, MEDE_ALTO=2, MEDE_BAIXO=3.
  - Default TIMEOUT and N constants for 50 MHz / 50 Hz servo framing.
- One sub-module, detector_borda: 2-FF synchronizer plus edge register, outputs s, sobe, desce; its own asynchronous active-low reset.
- The two counters are inline; they are not instances of the mod-M counter, because that counter wraps and these must saturate and be preloaded.

Test Plan:
- Reset then steady PWM, period 1000 ticks, high 150 (TIMEOUT=5000) -> first pronto after the second rising edge with largura=150, periodo=1000; pronto every 1000 cycles after that; erro_timeout=0.
- Start with pwm_in already high mid-pulse -> the partial pulse is ignored; the first pronto reports the full 150/1000.
- pwm_in held at 0 for 6000 cycles -> erro_timeout=1 exactly 5000 cycles after entering ESPERA_SUBIDA; largura/periodo unchanged; restoring PWM gives a pronto that clears erro_timeout.
- pwm_in stuck at 1 -> timeout when cont_per reaches 5000; no pronto.
- LARG_MIN=3 with 1-tick glitch pulses inserted between valid pulses -> glitch periods produce no pronto; valid 150/1000 measurements are unaffected once the cycle re-aligns.
- Assert zera_as_n mid MEDE_BAIXO, and separately drop habilita for 1 cycle -> all outputs reset (for reset) or held (for habilita); no spurious pronto; measurement resumes correctly.
